// File: rtl/display_pkg.sv
// Shared types and constants for the BCD seven-segment display controller:
// FSM encoding, active-low segment patterns, DP bit index and BCD helpers.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Active-low segments, bit7 = DP (off), bits6:0 = g..a
    localparam logic [7:0] SEG_0     = 8'b1100_0000;
    localparam logic [7:0] SEG_1     = 8'b1111_1001;
    localparam logic [7:0] SEG_2     = 8'b1010_0100;
    localparam logic [7:0] SEG_3     = 8'b1011_0000;
    localparam logic [7:0] SEG_4     = 8'b1001_1001;
    localparam logic [7:0] SEG_5     = 8'b1001_0010;
    localparam logic [7:0] SEG_6     = 8'b1000_0010;
    localparam logic [7:0] SEG_7     = 8'b1111_1000;
    localparam logic [7:0] SEG_8     = 8'b1000_0000;
    localparam logic [7:0] SEG_9     = 8'b1001_0000;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int DP_BIT = 7;

    // Digit code reserved for an unlit digit
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Double-dabble correction applied to a nibble before each shift
    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Digit to active-low seven-segment decoder with decimal-point control.
// Ports: dig_i (BCD digit, 4'hF = blank), dp_i (1 = light DP), seg_o.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] dig_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    logic [7:0] base;

    always_comb begin
        base = SEG_BLANK;
        unique case (dig_i)
            4'd0:    base = SEG_0;
            4'd1:    base = SEG_1;
            4'd2:    base = SEG_2;
            4'd3:    base = SEG_3;
            4'd4:    base = SEG_4;
            4'd5:    base = SEG_5;
            4'd6:    base = SEG_6;
            4'd7:    base = SEG_7;
            4'd8:    base = SEG_8;
            4'd9:    base = SEG_9;
            default: base = SEG_BLANK;
        endcase
    end

    // A blank digit stays fully dark even if a sign is pending
    always_comb begin
        seg_o = base;
        if (base != SEG_BLANK)
            seg_o[DP_BIT] = ~dp_i;
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Two-channel round-robin binary-to-BCD display controller driving HEX5..HEX0.
// Ports: CLK, RST_N, A/B_REQ, A/B_VAL, A/B_ACK, BUSY, HEX0..HEX5.
// Build option SIGNED_DISP_EN: show two's-complement magnitude, sign on MS DP.
module bcd_display_ctrl
    import display_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             A_REQ,
    input  logic [WIDTH-1:0] A_VAL,
    output logic             A_ACK,
    input  logic             B_REQ,
    input  logic [WIDTH-1:0] B_VAL,
    output logic             B_ACK,
    output logic             BUSY,
    output logic [7:0]       HEX0,
    output logic [7:0]       HEX1,
    output logic [7:0]       HEX2,
    output logic [7:0]       HEX3,
    output logic [7:0]       HEX4,
    output logic [7:0]       HEX5
);

    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             last_b_q, last_b_d;
    logic             cur_b_q, cur_b_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    a_dig_q, a_dig_d;
    logic [BW-1:0]    b_dig_q, b_dig_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;

    logic             pick_b;
    logic [WIDTH-1:0] sel_val;
    logic [WIDTH-1:0] mag;
    logic             val_neg;
    logic [BW-1:0]    bcd_adj;
    logic [BW+WIDTH-1:0] shf;

    // On a tie the channel not served last wins; pointer resets to B
    always_comb begin
        pick_b  = B_REQ && (!A_REQ || !last_b_q);
        sel_val = pick_b ? B_VAL : A_VAL;
`ifdef SIGNED_DISP_EN
        val_neg = sel_val[WIDTH-1];
        mag     = val_neg ? -sel_val : sel_val;
`else
        val_neg = 1'b0;
        mag     = sel_val;
`endif
    end

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < NDIG; i++)
            bcd_adj[4*i +: 4] = dd_adj(bcd_q[4*i +: 4]);
        shf = {bcd_adj, bin_q} << 1;
    end

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        cur_b_d  = cur_b_q;
        neg_d    = neg_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        a_dig_d  = a_dig_q;
        b_dig_d  = b_dig_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (A_REQ || B_REQ) begin
                    cur_b_d = pick_b;
                    neg_d   = val_neg;
                    bin_d   = mag;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                bin_d = shf[WIDTH-1:0];
                bcd_d = shf[WIDTH +: BW];
                cnt_d = cnt_q + CW'(1);
                // Digits land on the last shift so they show during DONE
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    if (cur_b_q) begin
                        b_dig_d = shf[WIDTH +: BW];
                        b_neg_d = neg_q;
                    end else begin
                        a_dig_d = shf[WIDTH +: BW];
                        a_neg_d = neg_q;
                    end
                end
            end
            ST_DONE: begin
                last_b_d = cur_b_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            last_b_q <= 1'b1;
            cur_b_q  <= 1'b0;
            neg_q    <= 1'b0;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            a_dig_q  <= {NDIG{DIG_BLANK}};
            b_dig_q  <= {NDIG{DIG_BLANK}};
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            cur_b_q  <= cur_b_d;
            neg_q    <= neg_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            a_dig_q  <= a_dig_d;
            b_dig_q  <= b_dig_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
        end
    end

    assign A_ACK = (state_q == ST_DONE) && !cur_b_q;
    assign B_ACK = (state_q == ST_DONE) &&  cur_b_q;
    assign BUSY  = (state_q != ST_IDLE);

    seg7_decode u_hex5 (.dig_i(a_dig_q[11:8]), .dp_i(a_neg_q), .seg_o(HEX5));
    seg7_decode u_hex4 (.dig_i(a_dig_q[7:4]),  .dp_i(1'b0),    .seg_o(HEX4));
    seg7_decode u_hex3 (.dig_i(a_dig_q[3:0]),  .dp_i(1'b0),    .seg_o(HEX3));
    seg7_decode u_hex2 (.dig_i(b_dig_q[11:8]), .dp_i(b_neg_q), .seg_o(HEX2));
    seg7_decode u_hex1 (.dig_i(b_dig_q[7:4]),  .dp_i(1'b0),    .seg_o(HEX1));
    seg7_decode u_hex0 (.dig_i(b_dig_q[3:0]),  .dp_i(1'b0),    .seg_o(HEX0));

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Scoreboard bench for bcd_display_ctrl: driver predicts grant order,
// timing and digits; monitor checks every ACK against the queue.
module tb_bcd_display_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       A_REQ = 1'b0, B_REQ = 1'b0;
    logic [7:0] A_VAL = 8'd0, B_VAL = 8'd0;
    logic       A_ACK, B_ACK, BUSY;
    logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    bcd_display_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_REQ(A_REQ), .A_VAL(A_VAL), .A_ACK(A_ACK),
        .B_REQ(B_REQ), .B_VAL(B_VAL), .B_ACK(B_ACK),
        .BUSY(BUSY),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
        .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    always #10 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    typedef struct {
        bit          chan_b;
        logic [23:0] hex;
        int          when;
    } exp_t;

    exp_t        q[$];
    logic [23:0] disp_a = 24'hFFFFFF;
    logic [23:0] disp_b = 24'hFFFFFF;
    bit          last_b = 1'b1;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Decimal digits from plain arithmetic, sign on the MS digit's DP
    function automatic logic [23:0] exp_hex(input logic [7:0] v);
        int          m;
        bit          neg;
        logic [7:0]  h2;
        m   = int'(v);
        neg = 1'b0;
`ifdef SIGNED_DISP_EN
        if (v[7]) begin
            neg = 1'b1;
            m   = 256 - int'(v);
        end
`endif
        h2 = SEG[m / 100];
        if (neg) h2[7] = 1'b0;
        return {h2, SEG[(m / 10) % 10], SEG[m % 10]};
    endfunction

    // Monitor: every ACK cycle pops one prediction
    always @(negedge CLK) begin
        if (RST_N && (A_ACK || B_ACK)) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", {30'd0, A_ACK, B_ACK}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ack_chan", {30'd0, A_ACK, B_ACK},
                    e.chan_b ? 32'd1 : 32'd2);
                chk("ack_cycle", cyc, e.when);
                chk("busy_in_done", {31'd0, BUSY}, 32'd1);
                if (e.chan_b) disp_b = e.hex;
                else          disp_a = e.hex;
                chk("hex_a", {8'd0, HEX5, HEX4, HEX3}, {8'd0, disp_a});
                chk("hex_b", {8'd0, HEX2, HEX1, HEX0}, {8'd0, disp_b});
            end
        end
    end

    task automatic txn(input bit ra, input bit rb,
                       input logic [7:0] va, input logic [7:0] vb);
        bit first_b;
        int n, pending;
        @(negedge CLK);
        A_VAL = va; B_VAL = vb;
        A_REQ = ra; B_REQ = rb;
        n = cyc;
        first_b = (ra && rb) ? !last_b : rb;
        q.push_back('{first_b, exp_hex(first_b ? vb : va), n + 9});
        if (ra && rb)
            q.push_back('{!first_b, exp_hex(first_b ? va : vb), n + 19});
        last_b = (ra && rb) ? !first_b : first_b;
        pending = int'(ra) + int'(rb);
        for (int k = 0; k < 40 && pending > 0; k++) begin
            @(negedge CLK);
            // Changing the value after grant must not reach the display
            if (k == 4) begin
                if (first_b) B_VAL = 8'($urandom);
                else         A_VAL = 8'($urandom);
            end
            if (A_ACK) begin A_REQ = 1'b0; pending--; end
            if (B_ACK) begin B_REQ = 1'b0; pending--; end
        end
        if (pending != 0) chk("txn_timeout", pending, 0);
        A_REQ = 1'b0; B_REQ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic check_blank(input string name);
        chk({name, "_hex"}, {16'd0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} == 64'hFFFF_FFFF_FFFF ? 32'd1 : 32'd0, 32'd1);
        chk({name, "_ctl"}, {29'd0, A_ACK, B_ACK, BUSY}, 32'd0);
    endtask

    initial begin
        logic [7:0] va, vb;
        bit ra, rb;
        int n, acks;
        bit nb;

        repeat (3) @(negedge CLK);
        check_blank("reset");
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        check_blank("idle_hold");

        // Tie right after reset: A first
        txn(1, 1, 8'd98, 8'd19);
`ifndef SIGNED_DISP_EN
        chk("tie_a_lit", {8'd0, HEX5, HEX4, HEX3}, 32'h00C09080);
        chk("tie_b_lit", {8'd0, HEX2, HEX1, HEX0}, 32'h00C0F990);
`endif
        txn(1, 0, 8'd240, 8'd0);
`ifndef SIGNED_DISP_EN
        chk("a240_lit", {8'd0, HEX5, HEX4, HEX3}, 32'h00A499C0);
`endif
        txn(1, 0, 8'hF0, 8'd0);
        txn(0, 1, 8'd0, 8'd0);
        txn(0, 1, 8'd0, 8'd255);
        txn(1, 1, 8'd128, 8'd127);
        txn(1, 1, 8'd99, 8'd100);

        // Fairness with both requests held
        @(negedge CLK);
        A_VAL = 8'd37; B_VAL = 8'd201;
        A_REQ = 1'b1; B_REQ = 1'b1;
        n = cyc;
        nb = !last_b;
        for (int i = 0; i < 6; i++) begin
            q.push_back('{nb, exp_hex(nb ? B_VAL : A_VAL), n + 9 + 10 * i});
            last_b = nb;
            nb = !nb;
        end
        acks = 0;
        for (int k = 0; k < 70 && acks < 6; k++) begin
            @(negedge CLK);
            if (A_ACK || B_ACK) acks++;
        end
        A_REQ = 1'b0; B_REQ = 1'b0;
        chk("fair_acks", acks, 6);
        @(negedge CLK);

        for (int t = 0; t < 30; t++) begin
            ra = 1'($urandom);
            rb = 1'($urandom);
            if (!ra && !rb) ra = 1'b1;
            va = 8'($urandom_range(0, 255));
            vb = 8'($urandom_range(0, 255));
            txn(ra, rb, va, vb);
        end

        // Reset in the middle of a conversion aborts it
        @(negedge CLK);
        A_VAL = 8'd240; A_REQ = 1'b1;
        repeat (5) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check_blank("mid_reset");
        A_REQ = 1'b0;
        q.delete();
        disp_a = 24'hFFFFFF;
        disp_b = 24'hFFFFFF;
        last_b = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (12) @(negedge CLK);
        check_blank("post_reset");

        // Pointer back at B after reset: A wins the tie again
        txn(1, 1, 8'd7, 8'd64);

        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
